// File: rtl/steer_en_pkg.sv
// Shared types and constants for the rider-detect / steering-enable sequencer.
package steer_en_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, STEER} steer_state_t;

  localparam logic [11:0] MIN_RIDER_WT  = 12'h200;
  localparam logic [11:0] WT_HYSTERESIS = 12'h040;
  localparam int unsigned TMR_W         = 26;
  localparam int unsigned FAST_TMR_BITS = 15;

  // Terminal count: 2^15-1 for simulation builds, 2^26-1 (~1.34 s at 50 MHz) otherwise.
  function automatic logic tmr_is_full(input logic [TMR_W-1:0] tmr, input logic fast);
    return fast ? (&tmr[FAST_TMR_BITS-1:0]) : (&tmr);
  endfunction

endpackage

// File: rtl/steer_en_cmp.sv
// Combinational load-cell datapath: total weight and left/right imbalance flags.
module steer_en_cmp
  import steer_en_pkg::*;
(
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16
);

  logic        [12:0] sum;
  logic signed [12:0] diff_s;
  logic        [11:0] absdiff;

  always_comb begin
    sum     = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff_s  = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
    absdiff = diff_s[12] ? 12'(-diff_s) : diff_s[11:0];

    sum_gt_min    = sum > {1'b0, MIN_RIDER_WT};
    sum_lt_min    = sum < {1'b0, MIN_RIDER_WT - WT_HYSTERESIS};
    diff_gt_1_4   = {1'b0, absdiff} > (sum >> 2);
    diff_gt_15_16 = {1'b0, absdiff} > (sum - (sum >> 4));
  end

endmodule

// File: rtl/steer_en.sv
// Rider-detect and steering-enable sequencer: IDLE / WAIT / STEER with a settle timer.
module steer_en
  import steer_en_pkg::*;
#(
  parameter logic fast_sim = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  logic sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
  logic tmr_full;

  steer_state_t     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             en_steer_q, en_steer_d;
  logic             rider_off_q, rider_off_d;

  steer_en_cmp u_cmp (
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16)
  );

  assign tmr_full = tmr_is_full(tmr_q, fast_sim);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      WAIT: begin
        // Rider loss outranks imbalance, which outranks timer expiry.
        if (sum_lt_min) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (diff_gt_1_4) begin
          tmr_d = '0;
        end else if (tmr_full) begin
          state_d = STEER;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (diff_gt_15_16) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register on the same edge.
    en_steer_d  = (state_d == STEER);
    rider_off_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
    end
  end

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en.sv
// Self-checking bench for steer_en: directed scenarios plus randomized loads vs. a timestamp-based model.
module tb_steer_en;

  localparam int unsigned SETTLE = 32768;

  logic        clk;
  logic        rst_n;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  steer_en #(.fast_sim(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Reference model: rider phases from the weight rules, settle measured as
  // elapsed edges since the most recent WAIT entry or imbalance restart.
  typedef enum int {M_IDLE, M_WAIT, M_STEER} m_phase_t;
  m_phase_t    m_phase = M_IDLE;
  int unsigned m_edge  = 0;
  int unsigned m_start = 0;

  function automatic int unsigned ld_sum(input int unsigned l, input int unsigned r);
    return l + r;
  endfunction

  function automatic int unsigned ld_diff(input int unsigned l, input int unsigned r);
    return (l > r) ? (l - r) : (r - l);
  endfunction

  function automatic bit heavy(input int unsigned l, input int unsigned r);
    return ld_sum(l, r) > 512;
  endfunction

  function automatic bit light(input int unsigned l, input int unsigned r);
    return ld_sum(l, r) < 448;
  endfunction

  function automatic bit tilted(input int unsigned l, input int unsigned r);
    return ld_diff(l, r) > ld_sum(l, r) / 4;
  endfunction

  function automatic bit severe(input int unsigned l, input int unsigned r);
    return ld_diff(l, r) > ld_sum(l, r) - ld_sum(l, r) / 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= M_IDLE;
    end else begin
      m_edge <= m_edge + 1;
      case (m_phase)
        M_IDLE:
          if (heavy(lft_ld, rght_ld)) begin
            m_phase <= M_WAIT;
            m_start <= m_edge + 1;
          end
        M_WAIT:
          if (light(lft_ld, rght_ld))                m_phase <= M_IDLE;
          else if (tilted(lft_ld, rght_ld))          m_start <= m_edge + 1;
          else if (m_edge + 1 - m_start >= SETTLE)   m_phase <= M_STEER;
        M_STEER:
          if (light(lft_ld, rght_ld))                m_phase <= M_IDLE;
          else if (severe(lft_ld, rght_ld)) begin
            m_phase <= M_WAIT;
            m_start <= m_edge + 1;
          end
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_en_steer", en_steer, m_phase == M_STEER);
    check("cyc_rider_off", rider_off, m_phase == M_IDLE);
  end

  task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    set_ld(12'h000, 12'h000);
    #1 rst_n = 1'b0;
    #1;
    check("rst_en_steer", en_steer, 1'b0);
    check("rst_rider_off", rider_off, 1'b1);
    run(3);
    rst_n = 1'b1;
    run(4);
    check("idle_zero_load", rider_off, 1'b1);

    // Weight boundaries: exactly 0x200 stays idle, 0x201 mounts, 0x1C0 holds, 0x1BF dismounts.
    set_ld(12'h100, 12'h100); run(4);
    check("idle_sum_200", rider_off, 1'b1);
    set_ld(12'h100, 12'h101); run(1);
    check("mount_sum_201", rider_off, 1'b0);
    set_ld(12'h0E0, 12'h0E0); run(5);
    check("wait_sum_1c0", rider_off, 1'b0);
    set_ld(12'h0E0, 12'h0DF); run(1);
    check("drop_sum_1bf", rider_off, 1'b1);

    // Mount, imbalance restarts the timer, then a full fresh count.
    set_ld(12'h180, 12'h180); run(1);
    check("mount_off", rider_off, 1'b0);
    run(100);
    set_ld(12'h300, 12'h080); run(200);
    check("imbal_en", en_steer, 1'b0);
    check("imbal_off", rider_off, 1'b0);
    set_ld(12'h1C0, 12'h1C0); run(SETTLE - 1);
    check("settle_early", en_steer, 1'b0);
    run(1);
    check("settle_done", en_steer, 1'b1);

    set_ld(12'h0F0, 12'h0F0); run(50);
    check("hyst_en", en_steer, 1'b1);
    check("hyst_off", rider_off, 1'b0);
    set_ld(12'h0D0, 12'h0D0); run(1);
    check("dismount_en", en_steer, 1'b0);
    check("dismount_off", rider_off, 1'b1);

    // Async reset in the middle of a settle count.
    set_ld(12'h180, 12'h180); run(1);
    run(16384);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midwait_rst_en", en_steer, 1'b0);
    check("midwait_rst_off", rider_off, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    check("rewait_off", rider_off, 1'b0);
    run(SETTLE - 1);
    check("resettle_early", en_steer, 1'b0);
    run(1);
    check("resettle_done", en_steer, 1'b1);

    set_ld(12'h3F0, 12'h008); run(1);
    check("severe_en", en_steer, 1'b0);
    check("severe_off", rider_off, 1'b0);

    // Random load episodes, weighted toward the threshold regions.
    for (int i = 0; i < 120; i++) begin
      logic [11:0] l, r;
      case ($urandom_range(0, 5))
        0: begin l = 12'($urandom_range(0, 12'h0E0)); r = 12'($urandom_range(0, 12'h0E0)); end
        1: begin l = 12'($urandom_range(12'h0D8, 12'h108)); r = 12'($urandom_range(12'h0D8, 12'h108)); end
        2: begin l = 12'($urandom_range(12'h100, 12'h400)); r = l + 12'($urandom_range(0, 12'h040)); end
        3: begin l = 12'($urandom_range(12'h200, 12'h500)); r = 12'($urandom_range(0, 12'h080)); end
        4: begin l = 12'hFFF; r = 12'($urandom_range(0, 12'hFFF)); end
        default: begin l = 12'($urandom); r = 12'($urandom); end
      endcase
      if ($urandom_range(0, 1) == 1) set_ld(r, l);
      else set_ld(l, r);
      run($urandom_range(1, 30));
    end

    run(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
